// File: rtl/shot_scheduler_if.sv
// Link between the shot scheduler and the trajectory calculator.
// The scheduler drives launch parameters and control; the calculator returns its result.
interface shot_scheduler_if;
    logic       calc_shoot;
    logic [4:0] calc_x;
    logic [4:0] calc_rise;
    logic [4:0] calc_run;
    logic       calc_dir;
    logic       calc_ena;
    logic       calc_clr;
    logic       calc_result_valid;
    logic       calc_hit;

    modport master (
        output calc_shoot, calc_x, calc_rise, calc_run, calc_dir, calc_ena, calc_clr,
        input  calc_result_valid, calc_hit
    );

    modport slave (
        input  calc_shoot, calc_x, calc_rise, calc_run, calc_dir, calc_ena, calc_clr,
        output calc_result_valid, calc_hit
    );
endinterface

// File: rtl/shot_scheduler.sv
// Two-player turn controller: round-robin shot arbitration, calculator launch/wait
// with timeout recovery, and per-player hit scoring up to the winning score.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a shot request, arbitrates and latches params
// S_LAUNCH  | one cycle; schedules the calc_shoot pulse
// S_WAIT    | waiting for calculator result, timeout counter running
// S_REPORT  | one cycle; shot_done/shot_hit visible, score already updated
// S_GAMEOVER| a player reached the win score; only new_game leaves
module shot_scheduler #(
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 7,
    parameter int TIMEOUT   = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [4:0]         p0_x,
    input  logic [4:0]         p0_rise,
    input  logic [4:0]         p0_run,
    input  logic               p0_dir,
    input  logic [4:0]         p1_x,
    input  logic [4:0]         p1_rise,
    input  logic [4:0]         p1_run,
    input  logic               p1_dir,
    input  logic               new_game,
    shot_scheduler_if.master   calc,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               shot_done,
    output logic               shot_hit,
    output logic               timeout_err,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_REPORT,
        S_GAMEOVER
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         calc_x_q, calc_x_d;
    logic [4:0]         calc_rise_q, calc_rise_d;
    logic [4:0]         calc_run_q, calc_run_d;
    logic               calc_dir_q, calc_dir_d;
    logic               calc_shoot_q, calc_shoot_d;
    logic               calc_clr_q, calc_clr_d;
    logic               busy_q, busy_d;
    logic               shot_done_q, shot_done_d;
    logic               shot_hit_q, shot_hit_d;
    logic               timeout_err_q, timeout_err_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;
    logic               pick;
    logic               won;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            calc_x_q      <= '0;
            calc_rise_q   <= '0;
            calc_run_q    <= '0;
            calc_dir_q    <= 1'b0;
            calc_shoot_q  <= 1'b0;
            calc_clr_q    <= 1'b0;
            busy_q        <= 1'b0;
            shot_done_q   <= 1'b0;
            shot_hit_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            score0_q      <= '0;
            score1_q      <= '0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            calc_x_q      <= calc_x_d;
            calc_rise_q   <= calc_rise_d;
            calc_run_q    <= calc_run_d;
            calc_dir_q    <= calc_dir_d;
            calc_shoot_q  <= calc_shoot_d;
            calc_clr_q    <= calc_clr_d;
            busy_q        <= busy_d;
            shot_done_q   <= shot_done_d;
            shot_hit_q    <= shot_hit_d;
            timeout_err_q <= timeout_err_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    // On a tie the player who did not shoot last wins; otherwise the lone requester.
    always_comb begin
        if (req == 2'b11) pick = ~last_grant_q;
        else              pick = req[1];
    end

    assign won = shot_hit_q && ((grant_q[1] ? score1_q : score0_q) == WIN_VAL);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        calc_x_d      = calc_x_q;
        calc_rise_d   = calc_rise_q;
        calc_run_d    = calc_run_q;
        calc_dir_d    = calc_dir_q;
        calc_shoot_d  = 1'b0;
        calc_clr_d    = 1'b0;
        shot_done_d   = 1'b0;
        shot_hit_d    = shot_hit_q;
        timeout_err_d = 1'b0;
        score0_d      = score0_q;
        score1_d      = score1_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    grant_d      = pick ? 2'b10 : 2'b01;
                    last_grant_d = pick;
                    calc_x_d     = pick ? p1_x    : p0_x;
                    calc_rise_d  = pick ? p1_rise : p0_rise;
                    calc_run_d   = pick ? p1_run  : p0_run;
                    calc_dir_d   = pick ? p1_dir  : p0_dir;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                calc_shoot_d = 1'b1;
                cnt_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Result and score are registered together so both appear with shot_done.
                if (calc.calc_result_valid) begin
                    shot_hit_d  = calc.calc_hit;
                    shot_done_d = 1'b1;
                    state_d     = S_REPORT;
                    if (calc.calc_hit) begin
                        if (grant_q[1])
                            score1_d = (score1_q == SCORE_MAX) ? score1_q : score1_q + SCORE_W'(1);
                        else
                            score0_d = (score0_q == SCORE_MAX) ? score0_q : score0_q + SCORE_W'(1);
                    end
                end else if (cnt_q == TIMEOUT_VAL) begin
                    shot_hit_d    = 1'b0;
                    shot_done_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    calc_clr_d    = 1'b1;
                    state_d       = S_REPORT;
                end
            end
            S_REPORT: begin
                grant_d = 2'b00;
                if (won) begin
                    game_over_d = 1'b1;
                    winner_d    = grant_q[1];
                    state_d     = S_GAMEOVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAMEOVER: begin
                state_d = S_GAMEOVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // new_game overrides everything, abandoning any shot without reporting it.
        if (new_game) begin
            state_d       = S_IDLE;
            grant_d       = 2'b00;
            last_grant_d  = 1'b1;
            cnt_d         = '0;
            calc_shoot_d  = 1'b0;
            calc_clr_d    = 1'b1;
            shot_done_d   = 1'b0;
            shot_hit_d    = 1'b0;
            timeout_err_d = 1'b0;
            score0_d      = '0;
            score1_d      = '0;
            game_over_d   = 1'b0;
            winner_d      = 1'b0;
        end

        busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    end

    assign calc.calc_shoot = calc_shoot_q;
    assign calc.calc_x     = calc_x_q;
    assign calc.calc_rise  = calc_rise_q;
    assign calc.calc_run   = calc_run_q;
    assign calc.calc_dir   = calc_dir_q;
    assign calc.calc_clr   = calc_clr_q;
    assign calc.calc_ena   = (state_q != S_GAMEOVER);

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign shot_done   = shot_done_q;
    assign shot_hit    = shot_hit_q;
    assign timeout_err = timeout_err_q;
    assign score0      = score0_q;
    assign score1      = score1_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule
